// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures the decoded bundle for execute, honours
// hazard-unit stall/flush and keeps saturating stall/bubble counters.
module id_ex_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic             RegWriteD,
  input  logic             ALUSrcD,
  input  logic             MemWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [2:0]       ALUControlD,
  input  logic [2:0]       funct3D,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic             ALUSrcE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [2:0]       funct3E,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             valid_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             reg_write_q, reg_write_d;
  logic             alu_src_q, alu_src_d;
  logic             mem_write_q, mem_write_d;
  logic             branch_q, branch_d;
  logic             jump_q, jump_d;
  logic [1:0]       result_src_q, result_src_d;
  logic [2:0]       alu_control_q, alu_control_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [XLEN-1:0]  rd1_q, rd1_d;
  logic [XLEN-1:0]  rd2_q, rd2_d;
  logic [XLEN-1:0]  imm_ext_q, imm_ext_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_plus4_q, pc_plus4_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic             valid_q, valid_d_int;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    reg_write_d   = reg_write_q;
    alu_src_d     = alu_src_q;
    mem_write_d   = mem_write_q;
    branch_d      = branch_q;
    jump_d        = jump_q;
    result_src_d  = result_src_q;
    alu_control_d = alu_control_q;
    funct3_d      = funct3_q;
    rd1_d         = rd1_q;
    rd2_d         = rd2_q;
    imm_ext_d     = imm_ext_q;
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    valid_d_int   = valid_q;
    stall_cnt_d   = stall_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;

    if (flush_e) begin
      // Bubble: everything cleared so nothing downstream can act on stale data.
      reg_write_d   = 1'b0;
      alu_src_d     = 1'b0;
      mem_write_d   = 1'b0;
      branch_d      = 1'b0;
      jump_d        = 1'b0;
      result_src_d  = '0;
      alu_control_d = '0;
      funct3_d      = '0;
      rd1_d         = '0;
      rd2_d         = '0;
      imm_ext_d     = '0;
      pc_d          = '0;
      pc_plus4_d    = '0;
      rs1_d         = '0;
      rs2_d         = '0;
      rd_d          = '0;
      valid_d_int   = 1'b0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (stall_e) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      // Control is gated by valid_d; data fields load unconditionally.
      reg_write_d   = RegWriteD & valid_d;
      alu_src_d     = ALUSrcD & valid_d;
      mem_write_d   = MemWriteD & valid_d;
      branch_d      = BranchD & valid_d;
      jump_d        = JumpD & valid_d;
      result_src_d  = valid_d ? ResultSrcD : 2'b00;
      alu_control_d = valid_d ? ALUControlD : 3'b000;
      funct3_d      = funct3D;
      rd1_d         = RD1D;
      rd2_d         = RD2D;
      imm_ext_d     = ImmExtD;
      pc_d          = PCD;
      pc_plus4_d    = PCPlus4D;
      rs1_d         = Rs1D;
      rs2_d         = Rs2D;
      rd_d          = RdD;
      valid_d_int   = valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      branch_q      <= 1'b0;
      jump_q        <= 1'b0;
      result_src_q  <= '0;
      alu_control_q <= '0;
      funct3_q      <= '0;
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_ext_q     <= '0;
      pc_q          <= '0;
      pc_plus4_q    <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      valid_q       <= 1'b0;
      stall_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      reg_write_q   <= reg_write_d;
      alu_src_q     <= alu_src_d;
      mem_write_q   <= mem_write_d;
      branch_q      <= branch_d;
      jump_q        <= jump_d;
      result_src_q  <= result_src_d;
      alu_control_q <= alu_control_d;
      funct3_q      <= funct3_d;
      rd1_q         <= rd1_d;
      rd2_q         <= rd2_d;
      imm_ext_q     <= imm_ext_d;
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      valid_q       <= valid_d_int;
      stall_cnt_q   <= stall_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  assign RegWriteE   = reg_write_q;
  assign ALUSrcE     = alu_src_q;
  assign MemWriteE   = mem_write_q;
  assign BranchE     = branch_q;
  assign JumpE       = jump_q;
  assign ResultSrcE  = result_src_q;
  assign ALUControlE = alu_control_q;
  assign funct3E     = funct3_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_ext_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc_plus4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign valid_e     = valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus random traffic, all checked
// against a bundle-level reference model (counters 4 bits wide to reach saturation).
module tb_id_ex_pipe_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, stall_e, flush_e, valid_d;
  logic RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD, funct3D;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0] ResultSrcE;
  logic [2:0] ALUControlE, funct3E;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic valid_e;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;

  typedef struct packed {
    logic rw, alusrc, mw, br, jp;
    logic [1:0] rsrc;
    logic [2:0] aluc, f3;
    logic [XLEN-1:0] rd1, rd2, imm, pc, pc4;
    logic [4:0] rs1, rs2, rd;
    logic v;
  } bundle_t;

  bundle_t exp_b;
  int exp_stalls, exp_bubbles;
  int chk_cnt = 0;
  int pass_cnt = 0;

  id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD),
    .ResultSrcD(ResultSrcD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUControlD(ALUControlD), .funct3D(funct3D),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .valid_e(valid_e),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // What the execute stage should see after an edge, stated as the rules:
  // reset clears, flush bubbles, stall holds, otherwise load (control only if valid).
  task automatic model_edge();
    bundle_t in_b;
    in_b = '{rw: RegWriteD, alusrc: ALUSrcD, mw: MemWriteD, br: BranchD, jp: JumpD,
             rsrc: ResultSrcD, aluc: ALUControlD, f3: funct3D,
             rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD, pc4: PCPlus4D,
             rs1: Rs1D, rs2: Rs2D, rd: RdD, v: valid_d};
    if (!valid_d) begin
      in_b.rw = 0; in_b.alusrc = 0; in_b.mw = 0; in_b.br = 0; in_b.jp = 0;
      in_b.rsrc = 0; in_b.aluc = 0;
    end
    if (!rst) begin
      exp_b = '0; exp_stalls = 0; exp_bubbles = 0;
    end else if (flush_e) begin
      exp_b = '0;
      exp_bubbles = (exp_bubbles < CMAX) ? exp_bubbles + 1 : CMAX;
    end else if (stall_e) begin
      exp_stalls = (exp_stalls < CMAX) ? exp_stalls + 1 : CMAX;
    end else begin
      exp_b = in_b;
    end
  endtask

  task automatic compare_all();
    check("RegWriteE", 64'(RegWriteE), 64'(exp_b.rw));
    check("ALUSrcE", 64'(ALUSrcE), 64'(exp_b.alusrc));
    check("MemWriteE", 64'(MemWriteE), 64'(exp_b.mw));
    check("BranchE", 64'(BranchE), 64'(exp_b.br));
    check("JumpE", 64'(JumpE), 64'(exp_b.jp));
    check("ResultSrcE", 64'(ResultSrcE), 64'(exp_b.rsrc));
    check("ALUControlE", 64'(ALUControlE), 64'(exp_b.aluc));
    check("funct3E", 64'(funct3E), 64'(exp_b.f3));
    check("RD1E", 64'(RD1E), 64'(exp_b.rd1));
    check("RD2E", 64'(RD2E), 64'(exp_b.rd2));
    check("ImmExtE", 64'(ImmExtE), 64'(exp_b.imm));
    check("PCE", 64'(PCE), 64'(exp_b.pc));
    check("PCPlus4E", 64'(PCPlus4E), 64'(exp_b.pc4));
    check("Rs1E", 64'(Rs1E), 64'(exp_b.rs1));
    check("Rs2E", 64'(Rs2E), 64'(exp_b.rs2));
    check("RdE", 64'(RdE), 64'(exp_b.rd));
    check("valid_e", 64'(valid_e), 64'(exp_b.v));
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stalls));
    check("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubbles));
    if (!valid_e)
      check("bubble_inv", 64'({RegWriteE, MemWriteE, BranchE, JumpE}), 64'(0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic rand_d();
    valid_d = ($urandom_range(0, 9) < 8);
    RegWriteD = 1'($urandom); ALUSrcD = 1'($urandom); MemWriteD = 1'($urandom);
    BranchD = 1'($urandom); JumpD = 1'($urandom);
    ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom); funct3D = 3'($urandom);
    RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
    PCD = $urandom; PCPlus4D = PCD + 32'd4;
    Rs1D = 5'($urandom); Rs2D = 5'($urandom); RdD = 5'($urandom);
  endtask

  task automatic clear_d();
    valid_d = 0; RegWriteD = 0; ALUSrcD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0;
    ResultSrcD = 0; ALUControlD = 0; funct3D = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  initial begin
    exp_b = '0; exp_stalls = 0; exp_bubbles = 0;
    rst = 0; stall_e = 0; flush_e = 0;
    rand_d();
    step(); step();

    // load
    rst = 1; clear_d();
    valid_d = 1; RD1D = 32'h0000_00AA; ImmExtD = 32'hFFFF_FFFC; ALUControlD = 3'b010; RdD = 5'd7;
    step();
    check("load_RD1E", 64'(RD1E), 64'h0000_00AA);
    check("load_ImmExtE", 64'(ImmExtE), 64'hFFFF_FFFC);
    check("load_ALUControlE", 64'(ALUControlE), 64'd2);
    check("load_RdE", 64'(RdE), 64'd7);
    check("load_valid_e", 64'(valid_e), 64'd1);

    // three stalled cycles with moving D inputs, then release
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step();
      check("stall_hold_RD1E", 64'(RD1E), 64'h0000_00AA);
    end
    check("stall_cnt_3", 64'(stall_cnt), 64'd3);
    stall_e = 0; rand_d(); valid_d = 1;
    step();
    check("release_RD1E", 64'(RD1E), 64'(RD1D));

    // flush wins over stall
    stall_e = 1; flush_e = 1; valid_d = 1; RegWriteD = 1; MemWriteD = 1;
    step();
    check("flush_valid_e", 64'(valid_e), 64'd0);
    check("flush_RegWriteE", 64'(RegWriteE), 64'd0);
    check("flush_MemWriteE", 64'(MemWriteE), 64'd0);
    check("flush_RdE", 64'(RdE), 64'd0);
    check("flush_bubble_cnt", 64'(bubble_cnt), 64'd1);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd3);

    // invalid decode
    stall_e = 0; flush_e = 0; clear_d();
    JumpD = 1; BranchD = 1; RD2D = 32'h1234;
    step();
    check("inv_JumpE", 64'(JumpE), 64'd0);
    check("inv_BranchE", 64'(BranchE), 64'd0);
    check("inv_valid_e", 64'(valid_e), 64'd0);
    check("inv_RD2E", 64'(RD2E), 64'h1234);

    // reset mid-stall
    clear_d(); valid_d = 1; RdD = 5'd5; RegWriteD = 1;
    step();
    check("pre_rst_RdE", 64'(RdE), 64'd5);
    rst = 0; stall_e = 1;
    step();
    check("rst_RdE", 64'(RdE), 64'd0);
    check("rst_RegWriteE", 64'(RegWriteE), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);

    // saturation
    rst = 1; stall_e = 0; flush_e = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_bubble_cnt", 64'(bubble_cnt), 64'(CMAX));
    flush_e = 0; stall_e = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_stall_cnt", 64'(stall_cnt), 64'(CMAX));

    // random traffic
    rst = 0; step();
    for (int i = 0; i < 500; i++) begin
      rand_d();
      rst = ($urandom_range(0, 99) >= 3);
      stall_e = ($urandom_range(0, 99) < 25);
      flush_e = ($urandom_range(0, 99) < 15);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
